// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the fetch/data memory port arbiter.
package mem_arb_pkg;
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_F_BEAT0 = 3'd1;
   localparam logic [2:0] S_F_BEAT1 = 3'd2;
   localparam logic [2:0] S_D_ACC   = 3'd3;
   localparam logic [2:0] S_RESP    = 3'd4;

   localparam int FETCH_BYTES = 10;
   localparam int WORD_BYTES  = 8;

   localparam logic OWN_F = 1'b0;
   localparam logic OWN_D = 1'b1;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the shared memory port.
interface mem_port_arbiter_if;
   logic        f_req;
   logic [63:0] f_addr;
   logic        f_ack;
   logic [79:0] f_data;
   logic        f_err;
   logic        d_req;
   logic        d_we;
   logic [63:0] d_addr;
   logic [63:0] d_wdata;
   logic        d_ack;
   logic [63:0] d_rdata;
   logic        d_err;
   logic        mem_req;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;
   logic        mem_ack;

   modport slave (
      input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
      output f_ack, f_data, f_err, d_ack, d_rdata, d_err,
             mem_req, mem_we, mem_addr, mem_wdata
   );
   modport master (
      output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
      input  f_ack, f_data, f_err, d_ack, d_rdata, d_err,
             mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter_bounds_chk.sv
// Range check: flags an access of len bytes at addr that runs past MEM_BYTES.
module mem_bounds_chk #(
   parameter int MEM_BYTES = 2048
) (
   input  logic [63:0] addr,
   input  logic [7:0]  len,
   output logic        err
);
   logic [64:0] end_addr;

   // 65-bit sum so addresses near 2^64 cannot wrap back into range
   assign end_addr = {1'b0, addr} + {57'd0, len};
   assign err      = end_addr > 65'(MEM_BYTES);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported 64-bit memory between fetch (two-beat 10-byte reads)
// and the memory stage (8-byte reads/writes), with range checking and streak-limited priority.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_BYTES       = 2048,
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic               clk,
   input  logic               reset,
   mem_port_arbiter_if.slave  bus
);
   localparam int SW = $clog2(MAX_DATA_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

   logic [2:0]    state;
   logic          own;
   logic [SW-1:0] streak;
   logic [63:0]   f_lo;
   logic          f_oob, d_oob, d_win;

   mem_bounds_chk #(.MEM_BYTES(MEM_BYTES)) u_f_chk (
      .addr(bus.f_addr), .len(8'(FETCH_BYTES)), .err(f_oob));
   mem_bounds_chk #(.MEM_BYTES(MEM_BYTES)) u_d_chk (
      .addr(bus.d_addr), .len(8'(WORD_BYTES)), .err(d_oob));

   assign d_win     = bus.d_req && (!bus.f_req || streak < STREAK_MAX);
   assign bus.f_ack = (state == S_RESP) && (own == OWN_F);
   assign bus.d_ack = (state == S_RESP) && (own == OWN_D);

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         own           <= OWN_F;
         streak        <= '0;
         f_lo          <= '0;
         bus.f_data    <= '0;
         bus.f_err     <= 1'b0;
         bus.d_rdata   <= '0;
         bus.d_err     <= 1'b0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
      end else begin
         if (!bus.f_req) streak <= '0;
         case (state)
            S_IDLE: begin
               if (d_win) begin
                  own <= OWN_D;
                  if (bus.f_req) streak <= streak + 1'b1;
                  if (d_oob) begin
                     bus.d_err   <= 1'b1;
                     bus.d_rdata <= '0;
                     state       <= S_RESP;
                  end else begin
                     bus.mem_req   <= 1'b1;
                     bus.mem_we    <= bus.d_we;
                     bus.mem_addr  <= bus.d_addr;
                     bus.mem_wdata <= bus.d_wdata;
                     state         <= S_D_ACC;
                  end
               end else if (bus.f_req) begin
                  own    <= OWN_F;
                  streak <= '0;
                  if (f_oob) begin
                     bus.f_err  <= 1'b1;
                     bus.f_data <= '0;
                     state      <= S_RESP;
                  end else begin
                     bus.mem_req   <= 1'b1;
                     bus.mem_we    <= 1'b0;
                     bus.mem_addr  <= bus.f_addr;
                     bus.mem_wdata <= '0;
                     state         <= S_F_BEAT0;
                  end
               end
            end
            S_F_BEAT0: if (bus.mem_ack) begin
               f_lo         <= bus.mem_rdata;
               bus.mem_addr <= bus.mem_addr + 64'd8;
               state        <= S_F_BEAT1;
            end
            S_F_BEAT1: if (bus.mem_ack) begin
               bus.mem_req <= 1'b0;
               bus.f_data  <= {bus.mem_rdata[15:0], f_lo};
               bus.f_err   <= 1'b0;
               state       <= S_RESP;
            end
            S_D_ACC: if (bus.mem_ack) begin
               // writes return zero so a stale read value never leaks to the pipe
               bus.mem_req <= 1'b0;
               bus.mem_we  <= 1'b0;
               bus.d_rdata <= bus.mem_we ? 64'd0 : bus.mem_rdata;
               bus.d_err   <= 1'b0;
               state       <= S_D_ACC + 3'd1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
